// File: rtl/my_data_pkg.sv
// Shared types and helpers for the my_data packer and its beat counter.
// Optional build macro: MY_DATA_PACKER_PARITY_EN (enables per-entry parity output).
package my_data_pkg;

  // Packer control states: FILL collects beats, HOLD presents the frame.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } my_data_state_e;

  // Default frame geometry. Modules override it through their own parameters.
  localparam int DEF_AUM = 4;
  localparam int DEF_BUM = 8;
  localparam int DEF_VUM = 2;

  // Entry word at the default geometry. Parameterised modules declare the same
  // [AUM-1:0][BUM-1:0] shape locally using their own parameters.
  typedef logic [DEF_AUM-1:0][DEF_BUM-1:0] my_data_word_t;

  // Width of a counter that runs over 0..n-1. A one-value counter still gets
  // one bit so that every signal keeps a legal width.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/my_data_packer_if.sv
// Beat-in / frame-out bus of the my_data packer.
// Optional build macro: MY_DATA_PACKER_PARITY_EN adds my_data_par.
//
// Handshake semantics, on both sides:
//   A beat transfers on a rising clk edge where in_valid && in_ready.
//   A frame transfers on a rising clk edge where out_valid && out_ready.
//   A source holds its valid (and payload) until the transfer; a sink may
//   raise or drop ready at any time. in_last has meaning only while
//   in_valid is high. my_data_abv and out_beats are stable while out_valid.
interface my_data_packer_if #(
  parameter int AUM = 4,
  parameter int BUM = 8,
  parameter int VUM = 2
);
  localparam int BW = $clog2(AUM * VUM + 1);

  logic [BUM-1:0]          in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [AUM-1:0][BUM-1:0] my_data_abv [VUM];
  logic [BW-1:0]           out_beats;
  logic                    out_valid;
  logic                    out_ready;
`ifdef MY_DATA_PACKER_PARITY_EN
  logic [VUM-1:0]          my_data_par;
`endif

`ifdef MY_DATA_PACKER_PARITY_EN
  // The packer itself.
  modport master (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, my_data_abv, out_beats, out_valid, my_data_par
  );
  // Beat source plus frame consumer around the packer.
  modport slave (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, my_data_abv, out_beats, out_valid, my_data_par
  );
`else
  // The packer itself.
  modport master (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, my_data_abv, out_beats, out_valid
  );
  // Beat source plus frame consumer around the packer.
  modport slave (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, my_data_abv, out_beats, out_valid
  );
`endif

endinterface

// File: rtl/my_data_beat_ctr.sv
// Lane/entry position counter for the packer. Lane runs fastest; when the
// lane wraps, the entry advances. The last position reports frame_wrap.
module my_data_beat_ctr
  import my_data_pkg::*;
#(
  parameter int AUM = 4,
  parameter int VUM = 2,
  parameter int LW  = clog2_min1(AUM),
  parameter int EW  = clog2_min1(VUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          incr,
  output logic [LW-1:0] lane,
  output logic [EW-1:0] entry,
  output logic          lane_wrap,
  output logic          frame_wrap
);

  // Wrap flags for the current position.
  always_comb begin
    lane_wrap  = (lane == LW'(AUM - 1));
    frame_wrap = lane_wrap && (entry == EW'(VUM - 1));
  end

  // Position register: clear wins over incr; the full frame wraps to 0/0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= '0;
      entry <= '0;
    end else if (clear) begin
      lane  <= '0;
      entry <= '0;
    end else if (incr) begin
      if (lane_wrap) begin
        lane  <= '0;
        entry <= frame_wrap ? '0 : entry + EW'(1);
      end else begin
        lane  <= lane + LW'(1);
      end
    end
  end

endmodule

// File: rtl/my_data_packer.sv
// my_data_packer: collects BUM-bit beats into a VUM x [AUM][BUM] frame and
// holds it for one consumer handshake. Frames end at the last slot or on
// in_last; unwritten slots read 0 because the buffer is zeroed on handoff.
// Optional build macro: MY_DATA_PACKER_PARITY_EN (per-entry XOR parity).
module my_data_packer
  import my_data_pkg::*;
#(
  parameter int AUM = 4,
  parameter int BUM = 8,
  parameter int VUM = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  my_data_packer_if.master       bus,
  output my_data_state_e         dbg_state
);

  localparam int BW = $clog2(AUM * VUM + 1);
  localparam int LW = clog2_min1(AUM);
  localparam int EW = clog2_min1(VUM);

  typedef logic [AUM-1:0][BUM-1:0] word_t;

  my_data_state_e state_q, state_d;
  logic           in_ready;
  logic           out_valid;
  logic           accept;
  logic           finish;
  logic           handoff;

  logic [LW-1:0]  lane;
  logic [EW-1:0]  entry;
  logic           lane_wrap;
  logic           frame_wrap;

  logic [BW-1:0]  beat_cnt;
  logic [BW-1:0]  beats_q;
  word_t          frame [VUM];
`ifdef MY_DATA_PACKER_PARITY_EN
  logic [VUM-1:0] par;
`endif

  my_data_beat_ctr #(
    .AUM (AUM),
    .VUM (VUM),
    .LW  (LW),
    .EW  (EW)
  ) u_beat_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (handoff),
    .incr       (accept),
    .lane       (lane),
    .entry      (entry),
    .lane_wrap  (lane_wrap),
    .frame_wrap (frame_wrap)
  );

  // Next state and handshake strobes; ready/valid come from state alone so
  // out_ready never reaches in_ready combinationally.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    handoff   = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
        if (accept && (frame_wrap || bus.in_last)) begin
          finish  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          handoff = 1'b1;
          state_d = FILL;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame buffer, beat count and parity: written per accepted beat, frozen
  // in HOLD, zeroed on handoff so a short frame never shows stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < VUM; e++) frame[e] <= '0;
      beat_cnt <= '0;
      beats_q  <= '0;
`ifdef MY_DATA_PACKER_PARITY_EN
      par      <= '0;
`endif
    end else if (handoff) begin
      for (int e = 0; e < VUM; e++) frame[e] <= '0;
      beat_cnt <= '0;
      beats_q  <= '0;
`ifdef MY_DATA_PACKER_PARITY_EN
      par      <= '0;
`endif
    end else if (accept) begin
      frame[entry][lane] <= bus.in_data;
      beat_cnt           <= beat_cnt + BW'(1);
      if (finish) beats_q <= beat_cnt + BW'(1);
`ifdef MY_DATA_PACKER_PARITY_EN
      par[entry]         <= par[entry] ^ (^bus.in_data);
`endif
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_beats   = beats_q;
  assign bus.my_data_abv = frame;
`ifdef MY_DATA_PACKER_PARITY_EN
  assign bus.my_data_par = par;
`endif
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_my_data_packer.sv
// Bench for my_data_packer: directed frames from the test plan, then random
// frames against a flat-array reference model, then a 1x1x3 instance.
// Optional build macro: MY_DATA_PACKER_PARITY_EN (parity checks enabled).
module tb_my_data_packer;
  import my_data_pkg::*;

  localparam int AUM = 4;
  localparam int BUM = 8;
  localparam int VUM = 2;
  localparam int NB  = AUM * VUM;
  localparam int EWD = AUM * BUM;
  localparam int FW  = EWD * VUM;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  my_data_packer_if #(.AUM(AUM), .BUM(BUM), .VUM(VUM)) bus ();
  my_data_state_e dbg_state;
  my_data_packer #(.AUM(AUM), .BUM(BUM), .VUM(VUM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  my_data_packer_if #(.AUM(1), .BUM(3), .VUM(1)) sbus ();
  my_data_state_e s_dbg_state;
  my_data_packer #(.AUM(1), .BUM(3), .VUM(1)) sdut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (sbus),
    .dbg_state (s_dbg_state)
  );

  // No X payload while a beat is offered.
  always @(posedge clk) begin
    if (rst_n && bus.in_valid) assert (!$isunknown(bus.in_data))
      else $error("in_data unknown while in_valid");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [BUM-1:0] beat_buf [NB];
  logic [FW-1:0]  exp_q [$];
  int             exp_n_q [$];
  logic [FW-1:0]  cur_frame;
  int             cur_n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat i lands at entry i/AUM, lane i%AUM: flat bit offset i*BUM.
  function automatic logic [FW-1:0] model_frame(input int n);
    logic [FW-1:0] f = '0;
    for (int i = 0; i < n; i++) f[i*BUM +: BUM] = beat_buf[i];
    return f;
  endfunction

  function automatic logic [VUM-1:0] model_par(input logic [FW-1:0] f);
    logic [VUM-1:0] p;
    for (int e = 0; e < VUM; e++) p[e] = ^f[e*EWD +: EWD];
    return p;
  endfunction

  function automatic logic [FW-1:0] dut_frame();
    logic [FW-1:0] f;
    for (int e = 0; e < VUM; e++) f[e*EWD +: EWD] = bus.my_data_abv[e];
    return f;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready), 64'(1));
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_out_beats"}, 64'(bus.out_beats), 64'(0));
    check({tag, "_frame"},     64'(dut_frame()), 64'(0));
    check({tag, "_state"},     64'(dbg_state), 64'(FILL));
`ifdef MY_DATA_PACKER_PARITY_EN
    check({tag, "_par"},       64'(bus.my_data_par), 64'(0));
`endif
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, "_in_ready"},  64'(bus.in_ready), 64'(0));
    check({tag, "_out_beats"}, 64'(bus.out_beats), 64'(cur_n));
    check({tag, "_frame"},     64'(dut_frame()), 64'(cur_frame));
`ifdef MY_DATA_PACKER_PARITY_EN
    check({tag, "_par"},       64'(bus.my_data_par), 64'(model_par(cur_frame)));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_frame(input int n, input bit use_last, input bit gaps, input string tag);
    exp_q.push_back(model_frame(n));
    exp_n_q.push_back(n);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid  = 1'b0;
          bus.in_last   = 1'($urandom_range(0, 1));
          bus.in_data   = BUM'($urandom);
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      bus.in_valid  = 1'b1;
      bus.in_data   = beat_buf[i];
      bus.in_last   = use_last && (i == n - 1);
      bus.out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      check({tag, "_fill_in_ready"},  64'(bus.in_ready), 64'(1));
      check({tag, "_fill_out_valid"}, 64'(bus.out_valid), 64'(0));
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    cur_frame = exp_q.pop_front();
    cur_n     = exp_n_q.pop_front();
    check_hold(tag);
  endtask

  task automatic stall(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = BUM'($urandom);
      bus.in_last   = 1'($urandom_range(0, 1));
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      check_hold(tag);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic handoff(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_idle(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    sbus.in_data   = '0;
    sbus.in_valid  = 1'b0;
    sbus.in_last   = 1'b0;
    sbus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("post_reset");

    // Full frame 0x11..0x88, then the same with 0x10 in the first slot.
    for (int i = 0; i < NB; i++) beat_buf[i] = BUM'((i + 1) * 8'h11);
    run_frame(NB, 1'b0, 1'b0, "full");
    handoff("full_release");
    beat_buf[0] = 8'h10;
    run_frame(NB, 1'b0, 1'b0, "full_par");
    handoff("full_par_release");

    // Short frame, then backpressure with in_valid held high.
    beat_buf[0] = 8'hA1; beat_buf[1] = 8'hA2; beat_buf[2] = 8'hA3;
    run_frame(3, 1'b1, 1'b0, "short");
    stall(10, "stall");
    handoff("stall_release");

    // Reset between clock edges after 5 beats.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = BUM'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("mid_partial_nonempty", 64'(dut_frame() != '0), 64'(1));
    #3 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NB; i++) beat_buf[i] = BUM'($urandom);
    run_frame(NB, 1'b0, 1'b0, "after_reset");
    handoff("after_reset_release");

    // Random frames with gaps, optional last, random stalls.
    for (int f = 0; f < 25; f++) begin
      int  n;
      bit  ul;
      n  = $urandom_range(1, NB);
      ul = (n < NB) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < NB; i++) beat_buf[i] = BUM'($urandom);
      run_frame(n, ul, 1'b1, "rand");
      stall($urandom_range(0, 3), "rand_stall");
      handoff("rand_release");
    end

    // AUM=VUM=1, BUM=3: each beat is a frame, one frame every 2 cycles.
    sbus.in_data   = 3'h5;
    sbus.in_valid  = 1'b1;
    sbus.out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check("small_out_valid", 64'(sbus.out_valid), 64'(k % 2));
      check("small_in_ready",  64'(sbus.in_ready), 64'(1 - (k % 2)));
      check("small_frame",     64'(sbus.my_data_abv[0]), (k % 2) ? 64'h5 : 64'h0);
      check("small_beats",     64'(sbus.out_beats), 64'(k % 2));
    end
    sbus.in_valid  = 1'b0;
    sbus.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
